// File: rtl/easy_fifo_axis_out.sv
// Drains a first-word-fall-through FIFO into an AXI4-Stream master through a
// 2-entry skid buffer, framing every PKT_LEN beats with tlast.
module easy_fifo_axis_out #(
  parameter  int unsigned DWIDTH  = 32,
  parameter  int unsigned PKT_LEN = 16,
  localparam int unsigned BW      = (PKT_LEN > 1) ? $clog2(PKT_LEN) : 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [DWIDTH-1:0] fifo_rd_data,
  input  logic              fifo_rd_empty,
  output logic              fifo_rd_en,
  output logic [DWIDTH-1:0] m_axis_tdata,
  output logic              m_axis_tvalid,
  output logic              m_axis_tlast,
  input  logic              m_axis_tready,
  output logic [BW-1:0]     beat_idx
);

  typedef enum logic [1:0] {
    S_EMPTY,
    S_ONE,
    S_TWO
  } state_t;

  state_t            r_state;
  state_t            w_state_nxt;

  logic [DWIDTH-1:0] r_tdata;
  logic              r_tlast;
  logic              r_tvalid;
  logic [DWIDTH-1:0] r_sdata;
  logic              r_slast;
  logic              r_svalid;
  logic [BW-1:0]     r_beat;

  logic              w_pop;
  logic              w_accept;
  logic              w_last_in;
  logic              w_load_out;
  logic              w_load_skid;
  logic              w_skid_to_out;

  // Pop depends only on skid occupancy, never on tready, so rd_en has no
  // combinational path from the downstream side.
  assign w_pop     = ~fifo_rd_empty & ~r_svalid & rst_n;
  assign w_accept  = r_tvalid & m_axis_tready;
  assign w_last_in = (r_beat == BW'(PKT_LEN - 1));

  always_comb begin
    w_state_nxt   = r_state;
    w_load_out    = 1'b0;
    w_load_skid   = 1'b0;
    w_skid_to_out = 1'b0;
    unique case (r_state)
      S_EMPTY: begin
        if (w_pop) begin
          w_state_nxt = S_ONE;
          w_load_out  = 1'b1;
        end
      end
      S_ONE: begin
        if (w_pop && w_accept) begin
          w_load_out = 1'b1;
        end else if (w_pop) begin
          w_state_nxt = S_TWO;
          w_load_skid = 1'b1;
        end else if (w_accept) begin
          w_state_nxt = S_EMPTY;
        end
      end
      S_TWO: begin
        if (w_accept) begin
          w_state_nxt   = S_ONE;
          w_skid_to_out = 1'b1;
        end
      end
      default: w_state_nxt = S_EMPTY;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= S_EMPTY;
      r_tvalid <= 1'b0;
      r_svalid <= 1'b0;
    end else begin
      r_state  <= w_state_nxt;
      r_tvalid <= (w_state_nxt != S_EMPTY);
      r_svalid <= (w_state_nxt == S_TWO);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_tdata <= '0;
      r_tlast <= 1'b0;
      r_sdata <= '0;
      r_slast <= 1'b0;
    end else begin
      if (w_load_out) begin
        r_tdata <= fifo_rd_data;
        r_tlast <= w_last_in;
      end else if (w_skid_to_out) begin
        r_tdata <= r_sdata;
        r_tlast <= r_slast;
      end
      if (w_load_skid) begin
        r_sdata <= fifo_rd_data;
        r_slast <= w_last_in;
      end
    end
  end

  // With PKT_LEN==1 every word is last, so the counter stays pinned at zero.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_beat <= '0;
    end else if (w_pop) begin
      r_beat <= w_last_in ? '0 : r_beat + BW'(1);
    end
  end

  assign fifo_rd_en    = w_pop;
  assign m_axis_tdata  = r_tdata;
  assign m_axis_tvalid = r_tvalid;
  assign m_axis_tlast  = r_tlast;
  assign beat_idx      = r_beat;

endmodule

// File: tb/tb_easy_fifo_axis_out.sv
// Four drain stages (PKT_LEN 4,7,1,8) fed by behavioural FIFOs and checked
// against an ordered scoreboard with packet framing computed from beat counts.
module tb_easy_fifo_axis_out;

  localparam int unsigned NL = 4;
  localparam int unsigned PL [NL] = '{4, 7, 1, 8};

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;

  logic [31:0] fmem [NL][4096];
  logic [11:0] head [NL];
  logic [11:0] tail [NL];
  logic [11:0] rx   [NL];
  int unsigned npop  [NL];
  int unsigned nbeat [NL];

  logic        rd_en   [NL];
  logic        empty   [NL];
  logic [31:0] rd_data [NL];
  logic [31:0] tdata   [NL];
  logic        tvalid  [NL];
  logic        tlast   [NL];
  logic        tready  [NL];
  logic [31:0] beat_all[NL];

  logic        stall      [NL];
  logic [31:0] stall_data [NL];
  logic        stall_last [NL];
  logic        smp_rden   [NL];
  logic        smp_tvalid [NL];
  logic        smp_tlast  [NL];
  logic        smp_acc    [NL];
  logic [31:0] smp_tdata  [NL];

  int unsigned n_checks = 0;
  int unsigned n_errors = 0;

  for (genvar g = 0; g < NL; g++) begin : lane
    localparam int unsigned BW = (PL[g] > 1) ? $clog2(PL[g]) : 1;
    logic [BW-1:0] w_beat;
    easy_fifo_axis_out #(.DWIDTH(32), .PKT_LEN(PL[g])) u_dut (
      .clk           (clk),
      .rst_n         (rst_n),
      .fifo_rd_data  (rd_data[g]),
      .fifo_rd_empty (empty[g]),
      .fifo_rd_en    (rd_en[g]),
      .m_axis_tdata  (tdata[g]),
      .m_axis_tvalid (tvalid[g]),
      .m_axis_tlast  (tlast[g]),
      .m_axis_tready (tready[g]),
      .beat_idx      (w_beat)
    );
    assign beat_all[g] = 32'(w_beat);
    assign rd_data[g]  = fmem[g][head[g]];
    assign empty[g]    = (head[g] == tail[g]);
  end

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  task automatic push(input int unsigned i, input logic [31:0] w);
    fmem[i][tail[i]] = w;
    tail[i] = tail[i] + 12'd1;
  endtask

  // One clock: sample/check at negedge, apply FIFO pops just after posedge.
  task automatic step();
    @(negedge clk);
    for (int i = 0; i < NL; i++) begin
      smp_rden[i]   = rd_en[i];
      smp_tvalid[i] = tvalid[i];
      smp_tdata[i]  = tdata[i];
      smp_tlast[i]  = tlast[i];
      smp_acc[i]    = tvalid[i] & tready[i];
      if (!rst_n) begin
        check("rst_rd_en",  32'(rd_en[i]),  32'd0);
        check("rst_tvalid", 32'(tvalid[i]), 32'd0);
        check("rst_tlast",  32'(tlast[i]),  32'd0);
        check("rst_tdata",  tdata[i],       32'd0);
        check("rst_beat",   beat_all[i],    32'd0);
      end else begin
        check("beat_idx", beat_all[i], 32'(npop[i] % PL[i]));
        if (rd_en[i]) check("pop_when_empty", 32'(head[i] != tail[i]), 32'd1);
        if (stall[i]) begin
          check("stall_tvalid", 32'(tvalid[i]), 32'd1);
          check("stall_tdata",  tdata[i],       stall_data[i]);
          check("stall_tlast",  32'(tlast[i]),  32'(stall_last[i]));
        end
        if (smp_acc[i]) begin
          check("sb_tdata", tdata[i], fmem[i][rx[i]]);
          check("sb_tlast", 32'(tlast[i]), 32'((nbeat[i] % PL[i]) == PL[i] - 1));
          rx[i] = rx[i] + 12'd1;
          nbeat[i]++;
        end
        stall[i]      = tvalid[i] & ~tready[i];
        stall_data[i] = tdata[i];
        stall_last[i] = tlast[i];
      end
    end
    @(posedge clk);
    #1;
    for (int i = 0; i < NL; i++) begin
      if (smp_rden[i] && rst_n) begin
        head[i] = head[i] + 12'd1;
        npop[i]++;
      end
    end
  endtask

  // Words already popped into the stage are lost; delivery restarts at FIFO head.
  task automatic do_reset(input int unsigned cycles);
    rst_n = 1'b0;
    for (int i = 0; i < NL; i++) begin
      rx[i]    = head[i];
      npop[i]  = 0;
      nbeat[i] = 0;
      stall[i] = 1'b0;
    end
    repeat (cycles) step();
    rst_n = 1'b1;
  endtask

  task automatic drain(input int unsigned i, input int unsigned budget, input bit rnd);
    int unsigned n = 0;
    while (rx[i] != tail[i] && n < budget) begin
      tready[i] = rnd ? ($urandom_range(0, 1) == 1) : 1'b1;
      step();
      n++;
    end
    check("drain_complete", 32'(rx[i]), 32'(tail[i]));
    tready[i] = 1'b1;
  endtask

  initial begin
    int unsigned pops;
    int unsigned pushed;
    int unsigned n;
    for (int i = 0; i < NL; i++) begin
      head[i] = '0; tail[i] = '0; rx[i] = '0;
      npop[i] = 0; nbeat[i] = 0; stall[i] = 1'b0;
      tready[i] = 1'b1;
    end
    #1;

    // Reset held with FIFO non-empty, then first-pop latency
    rst_n = 1'b0;
    push(0, 32'hA0); push(0, 32'hA1); push(0, 32'hA2);
    repeat (3) step();
    rst_n = 1'b1;
    step();
    check("t1_first_rd_en",   32'(smp_rden[0]),   32'd1);
    check("t1_tvalid_before", 32'(smp_tvalid[0]), 32'd0);
    step();
    check("t1_tvalid_after",  32'(smp_tvalid[0]), 32'd1);
    check("t1_first_tdata",   smp_tdata[0],       32'hA0);
    drain(0, 50, 1'b0);

    // Streaming, PKT_LEN=4
    do_reset(2);
    for (int k = 0; k < 12; k++) push(0, 32'(k));
    step();
    check("t2_no_beat_yet", 32'(smp_acc[0]), 32'd0);
    for (int k = 0; k < 12; k++) begin
      step();
      check("t2_beat_each_cycle", 32'(smp_acc[0]), 32'd1);
      check("t2_tdata", smp_tdata[0], 32'(k));
      check("t2_tlast", 32'(smp_tlast[0]), 32'((k % 4) == 3));
    end
    step();
    check("t2_idle_after", 32'(smp_acc[0]), 32'd0);

    // Backpressure: only two words may leave the FIFO
    do_reset(2);
    tready[0] = 1'b0;
    for (int k = 0; k < 5; k++) push(0, 32'(k));
    pops = 0;
    repeat (6) begin
      step();
      if (smp_rden[0]) pops++;
    end
    check("t3_pop_count", pops, 32'd2);
    check("t3_rd_en_low", 32'(smp_rden[0]),   32'd0);
    check("t3_tvalid",    32'(smp_tvalid[0]), 32'd1);
    check("t3_tdata",     smp_tdata[0],       32'd0);
    drain(0, 50, 1'b0);

    // Random traffic with random tready, PKT_LEN=7
    do_reset(2);
    pushed = 0;
    n = 0;
    while (pushed < 1000 && n < 4000) begin
      for (int k = $urandom_range(0, 2); k > 0 && pushed < 1000; k--) begin
        push(1, $urandom);
        pushed++;
      end
      tready[1] = ($urandom_range(0, 1) == 1);
      step();
      n++;
    end
    check("t4_all_pushed", pushed, 32'd1000);
    drain(1, 4000, 1'b1);
    check("t4_beats", nbeat[1], 32'd1000);

    // PKT_LEN=1
    do_reset(2);
    for (int k = 0; k < 20; k++) push(2, $urandom);
    drain(2, 400, 1'b1);
    check("t5_beats", nbeat[2], 32'd20);

    // Mid-packet reset, PKT_LEN=8
    do_reset(2);
    for (int k = 0; k < 20; k++) push(3, 32'(100 + k));
    n = 0;
    while (nbeat[3] < 5 && n < 50) begin
      step();
      n++;
    end
    check("t6_five_beats", nbeat[3], 32'd5);
    do_reset(2);
    drain(3, 200, 1'b0);
    check("t6_post_reset_beats", 32'(nbeat[3] >= 8), 32'd1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
